rf_write_ctrl: RTL and testbench
================================

# rf_write_ctrl

Parametrised register-file write-back controller for the MIPS32 datapath. It sits between the write-back stage and the register-file write port. It accepts qualified write requests through a valid/ready handshake and buffers them in an in-order queue. It drains the queue to the register file, one registered synchronous write enable per cycle, and never gates the clock. It also gives decode a pending-write lookup for hazard checks, and it discards writes to `$zero`.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 4, queue entries; power of two, ≥ 2
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  write-back stage presents a request
- `req_regwr`  in  1  RegWrite control qualifier
- `req_wben`  in  1  write-back enable qualifier
- `req_addr`  in  ADDR_W  destination register
- `req_data`  in  DATA_W  write data
- `req_ready`  out  1  queue can accept a request this cycle
- `rf_stall`  in  1  register-file port unavailable; hold the queue
- `rf_we`  out  1  registered write enable to the register file
- `rf_waddr`  out  ADDR_W  registered write address
- `rf_wdata`  out  DATA_W  registered write data
- `chk_addr`  in  ADDR_W  decode hazard-lookup address
- `chk_pending`  out  1  a write to `chk_addr` is queued or in flight
- `count`  out  clog2(DEPTH+1)  current queue occupancy

## Operation
- **Handshake.** A request is accepted when `req_valid && req_ready`.
- **Ready.** `req_ready = (count < DEPTH)`. It is combinational from registered state only and does not depend on `req_valid`.
- **Qualification.** An accepted request is enqueued only if `req_regwr && req_wben && req_addr != 0`. Otherwise it is consumed and dropped: the handshake completes and the queue is unchanged.
- **Drain.** When `!rf_stall && count > 0`, the head is popped. On the same edge, the outputs load `rf_we=1`, `rf_waddr=head.addr` and `rf_wdata=head.data`. Every other cycle loads `rf_we=0`; `rf_waddr` and `rf_wdata` hold their values.
- **Ordering.** The queue is strictly FIFO. Multiple entries to the same address drain in order, so the last one wins.
- **Push and pop together.** A push and a pop on the same edge leave `count` unchanged and move both pointers.
- **Full queue.** When full, `req_ready=0` even if a pop occurs on that edge. There is no pass-through.
- **Wrap-around.** Read and write pointers are `clog2(DEPTH)` bits and wrap modulo `DEPTH`. Full and empty are decided by `count` only.
- **Hazard lookup.** `chk_pending` is combinational: `chk_addr != 0` AND (any valid queue entry has that address OR (`rf_we && rf_waddr == chk_addr`)).
- **Reset.** `rst_n` low clears, asynchronously: `count=0`, both pointers 0, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, and all valid bits.
  - With the queue empty, `req_ready=1` and `chk_pending=0`.
  - Reset in mid-operation discards every queued and in-flight write; none reaches the register file.
  - Queue data storage itself need not be reset.

## Timing
- **Latency.** A request accepted at edge t into an empty queue, with `rf_stall=0`, is popped at edge t+1. `rf_we` is high for the cycle after t+1, and the register file captures the write at edge t+2.
- **Stall.** Each stalled cycle adds one cycle of latency to every entry.
- **Throughput.** One write per cycle, sustained, while `rf_stall=0`.
- **`rf_stall` changes.** `rf_stall` is sampled at the pop edge only. A stall asserted while `rf_we=1` does not cancel that write.
- **`chk_pending` window.** It rises in the cycle after acceptance and falls in the cycle after the register-file write edge. An entry therefore reads as pending exactly while the register file still holds the old value.

## Structure
- **Shared package `mips32_pkg`.** Holds the `DATA_W`/`ADDR_W` defaults, a `ZERO_REG` constant of 0, and a `wb_req_t` struct {addr, data}.
- **Sub-module `wb_fifo`.** Parametrised on `DEPTH` and the `wb_req_t` payload.
  - It holds the storage, pointers, `count` and per-entry valid bits.
  - It exports the valid and addr vectors for the `chk_pending` compare.
- **Top level.** Contains the qualification, the output registers and the hazard compare.

## Test plan
- **Single write.** Reset, then one request (addr 5, data `0xDEADBEEF`, both qualifiers high) at edge 1, `rf_stall=0` → `rf_we=1` with addr 5 and data `0xDEADBEEF` in exactly the cycle after edge 2. `chk_pending` for addr 5 is high from cycle 2 through that cycle.
- **Drops.** Requests to addr 0, and requests with `req_regwr=0` or `req_wben=0` → the handshake completes, `count` stays 0, and `rf_we` never rises.
- **Fill, wrap and order.** Hold `rf_stall=1` and push 4 entries (addrs 1–4) → `count=4` and `req_ready=0`. A 5th valid request is held off. Release the stall while pushing continuously → writes emerge as 1, 2, 3, 4, 5, … with no gaps or reordering across several pointer wraps.
- **Same address.** Push two writes to addr 7 (`0x11`, then `0x22`) → they drain in that order. `chk_pending` for addr 7 stays high until the write of `0x22` has completed.
- **Push and pop when full.** With `count=4`, pop with a request valid on the same edge → the request is not accepted and `count` goes to 3. On the next cycle `req_ready=1` and the request is accepted.
- **Reset mid-operation.** With 3 entries queued and `rf_we=1`, assert `rst_n` low mid-cycle → `rf_we` drops immediately, and `count=0`, `req_ready=1`, `chk_pending=0`. After release, no stale write appears.

Source files
------------

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared MIPS32 datapath types and constants
package mips32_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_write_ctrl_if.sv
// rtl/rf_write_ctrl_if.sv - write-back request handshake bundle
interface rf_write_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_regwr;
    logic              req_wben;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;

    modport master (
        output req_valid, req_regwr, req_wben, req_addr, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_regwr, req_wben, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order write-back queue with per-entry valid bits
import mips32_pkg::*;

module wb_fifo #(
    parameter int  DEPTH = 4,
    parameter type payload_t = wb_req_t,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  payload_t       push_data_i,
    input  logic           pop_i,
    output payload_t       head_o,
    output logic [CW-1:0]  count_o,
    output logic [DEPTH-1:0] valid_o,
    output payload_t       entry_o [DEPTH]
);

    payload_t         mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop_i) begin
            rd_ptr_d          = rd_ptr_q + PW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            wr_ptr_d          = wr_ptr_q + PW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign valid_o = valid_q;
    assign entry_o = mem_q;

endmodule

// File: rtl/rf_write_ctrl.sv
// rtl/rf_write_ctrl.sv - register-file write-back controller: qualify, queue, drain, hazard lookup
import mips32_pkg::*;

module rf_write_ctrl #(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter int  DEPTH  = 4,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_write_ctrl_if.slave     req,
    input  logic               rf_stall,
    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    input  logic [ADDR_W-1:0]  chk_addr,
    output logic               chk_pending,
    output logic [CW-1:0]      count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);

    logic             accept, push, pop;
    req_t             push_data, head;
    logic [CW-1:0]    count_w;
    logic [DEPTH-1:0] valid_w;
    req_t             entry_w [DEPTH];

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    // Ready looks only at registered occupancy, so a full queue stays closed
    // even on an edge where the head is being popped.
    assign req.req_ready = (count_w < DEPTH_C);
    assign accept        = req.req_valid && req.req_ready;
    assign push          = accept && req.req_regwr && req.req_wben
                           && (req.req_addr != ZERO_A);
    assign pop           = !rf_stall && (count_w != '0);
    assign push_data     = '{addr: req.req_addr, data: req.req_data};

    wb_fifo #(
        .DEPTH     (DEPTH),
        .payload_t (req_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count_w),
        .valid_o     (valid_w),
        .entry_o     (entry_w)
    );

    always_comb begin
        rf_we_d    = pop;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pop) begin
            rf_waddr_d = head.addr;
            rf_wdata_d = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Pending covers queued entries plus the write currently on the port.
    always_comb begin
        logic hit;
        hit = rf_we_q && (rf_waddr_q == chk_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_w[i] && (entry_w[i].addr == chk_addr)) begin
                hit = 1'b1;
            end
        end
        chk_pending = hit && (chk_addr != ZERO_A);
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign count    = count_w;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb/tb_rf_write_ctrl.sv - randomized and directed bench against a queue-based model
module tb_rf_write_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rf_stall = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_addr = '0;
    logic        chk_pending;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_write_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (bus),
        .rf_stall    (rf_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_pending(input logic [4:0] ca);
        if (ca == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == ca) return 1'b1;
        return m_we && (m_waddr == ca);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic step(input logic v, input logic rw, input logic wb, input logic [4:0] a,
                        input logic [31:0] d, input logic st, input logic [4:0] ca,
                        output logic acc);
        logic m_ready, m_pop;
        ent_t e;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_regwr = rw;
        bus.req_wben  = wb;
        bus.req_addr  = a;
        bus.req_data  = d;
        rf_stall      = st;
        chk_addr      = ca;
        #2;
        m_ready = (mq.size() < DEPTH);
        check("req_ready", 64'(bus.req_ready), 64'(m_ready));
        check("count", 64'(count), 64'(mq.size()));
        check("rf_we", 64'(rf_we), 64'(m_we));
        check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        check("chk_pending", 64'(chk_pending), 64'(m_pending(ca)));
        acc   = v && m_ready;
        m_pop = !st && (mq.size() > 0);
        @(posedge clk);
        if (m_pop) begin
            e       = mq.pop_front();
            m_we    = 1'b1;
            m_waddr = e.a;
            m_wdata = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (acc && rw && wb && a != 5'd0) mq.push_back('{a: a, d: d});
    endtask

    task automatic idle(input int n, input logic [4:0] ca);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, ca, acc);
    endtask

    initial begin
        logic       acc;
        logic [4:0] nxt;
        bus.req_valid = 1'b0;
        bus.req_regwr = 1'b0;
        bus.req_wben  = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_pending", 64'(chk_pending), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write: accept at edge 1, rf_we high in the cycle after edge 2.
        step(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, acc);
        check("single_acc", 64'(acc), 64'd1);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, acc);
        #2;
        check("single_we", 64'(rf_we), 64'd1);
        check("single_addr", 64'(rf_waddr), 64'd5);
        check("single_data", 64'(rf_wdata), 64'hDEADBEEF);
        check("single_pend", 64'(chk_pending), 64'd1);
        idle(1, 5'd5);
        #2;
        check("single_we_off", 64'(rf_we), 64'd0);
        check("single_pend_off", 64'(chk_pending), 64'd0);

        // Drops: zero register and each missing qualifier.
        step(1'b1, 1'b1, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, acc);
        check("drop_zero_acc", 64'(acc), 64'd1);
        step(1'b1, 1'b0, 1'b1, 5'd3, 32'h2, 1'b0, 5'd3, acc);
        step(1'b1, 1'b1, 1'b0, 5'd3, 32'h3, 1'b0, 5'd3, acc);
        idle(2, 5'd3);
        #2;
        check("drop_count", 64'(count), 64'd0);
        check("drop_we", 64'(rf_we), 64'd0);

        // Fill under stall, hold off a 5th, then stream across pointer wraps.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b1, 1'b1, 5'(i), 32'(i * 16), 1'b1, 5'(i), acc);
        #2;
        check("fill_count", 64'(count), 64'd4);
        check("fill_ready", 64'(bus.req_ready), 64'd0);
        step(1'b1, 1'b1, 1'b1, 5'd5, 32'd80, 1'b1, 5'd5, acc);
        check("fill_held", 64'(acc), 64'd0);
        nxt = 5'd5;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, 1'b1, nxt, 32'(nxt) * 16, 1'b0, nxt, acc);
            if (acc) nxt = (nxt == 5'd31) ? 5'd1 : nxt + 5'd1;
        end
        idle(6, 5'd1);

        // Same address twice, pending until the second write retires.
        step(1'b1, 1'b1, 1'b1, 5'd7, 32'h11, 1'b0, 5'd7, acc);
        step(1'b1, 1'b1, 1'b1, 5'd7, 32'h22, 1'b0, 5'd7, acc);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, acc);
        #2;
        check("same_data2", 64'(rf_wdata), 64'h22);
        check("same_pend", 64'(chk_pending), 64'd1);
        idle(2, 5'd7);

        // Push and pop on a full queue.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1, 5'(8 + i), 32'(i), 1'b1, 5'd8, acc);
        step(1'b1, 1'b1, 1'b1, 5'd12, 32'hC, 1'b0, 5'd12, acc);
        check("fullpp_acc", 64'(acc), 64'd0);
        #2;
        check("fullpp_count", 64'(count), 64'd3);
        step(1'b1, 1'b1, 1'b1, 5'd12, 32'hC, 1'b0, 5'd12, acc);
        check("fullpp_acc2", 64'(acc), 64'd1);
        idle(6, 5'd12);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), acc);
        end
        idle(6, 5'd0);

        // Reset mid-operation with 3 queued and a write on the port.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1, 5'(20 + i), 32'(100 + i), 1'b1, 5'd21, acc);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd21, acc);
        @(negedge clk);
        #2;
        check("pre_rst_we", 64'(rf_we), 64'd1);
        check("pre_rst_count", 64'(count), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 64'(rf_we), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_ready", 64'(bus.req_ready), 64'd1);
        check("mid_rst_pend", 64'(chk_pending), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6, 5'd22);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
